// File: rtl/slt_seq_unit.sv
// Multi-cycle set-less-than unit (SLT/SLTU). It compares the operands MSB-first, DIGIT bits per clock.
// Define SLT_SEQ_CONST_LAT_EN to disable early exit, so every compare takes exactly CHUNKS cycles.
module slt_seq_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] slt
);

  localparam int CHUNKS = WIDTH / DIGIT;
  localparam int CW     = $clog2(CHUNKS + 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, sa_nx, sb_nx, slt_nx;
  logic [CW-1:0]    count, count_nx;
  logic             done_nx;
  logic [WIDTH-1:0] flip;
  logic [DIGIT-1:0] ta, tb;
  logic             chunk_lt;

  // Flipping the sign bit maps two's-complement order onto unsigned order
  assign flip     = is_signed ? MSB_MASK : '0;
  assign ta       = sa[WIDTH-1 -: DIGIT];
  assign tb       = sb[WIDTH-1 -: DIGIT];
  assign chunk_lt = (ta < tb);
  assign busy     = (state == COMPARE);

`ifdef SLT_SEQ_CONST_LAT_EN
  logic decided, decided_nx, lt_hold, lt_hold_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decided <= 1'b0;
      lt_hold <= 1'b0;
    end else begin
      decided <= decided_nx;
      lt_hold <= lt_hold_nx;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      count <= '0;
      slt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sa    <= sa_nx;
      sb    <= sb_nx;
      count <= count_nx;
      slt   <= slt_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sa_nx    = sa;
    sb_nx    = sb;
    count_nx = count;
    slt_nx   = slt;
    done_nx  = 1'b0;
`ifdef SLT_SEQ_CONST_LAT_EN
    decided_nx = decided;
    lt_hold_nx = lt_hold;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          sa_nx    = value1 ^ flip;
          sb_nx    = value2 ^ flip;
          count_nx = CW'(CHUNKS);
          state_nx = COMPARE;
`ifdef SLT_SEQ_CONST_LAT_EN
          decided_nx = 1'b0;
          lt_hold_nx = 1'b0;
`endif
        end
      end
      COMPARE: begin
`ifdef SLT_SEQ_CONST_LAT_EN
        // The first differing chunk wins; later chunks only keep the pipeline timing fixed
        if (count == CW'(1)) begin
          slt_nx   = {WIDTH{decided ? lt_hold : chunk_lt}};
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          if (!decided && (ta != tb)) begin
            decided_nx = 1'b1;
            lt_hold_nx = chunk_lt;
          end
          sa_nx    = sa << DIGIT;
          sb_nx    = sb << DIGIT;
          count_nx = count - CW'(1);
        end
`else
        if ((ta != tb) || (count == CW'(1))) begin
          slt_nx   = {WIDTH{chunk_lt}};
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          sa_nx    = sa << DIGIT;
          sb_nx    = sb << DIGIT;
          count_nx = count - CW'(1);
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
